// File: rtl/mult_pkg.sv
// Shared types for the sequential Booth multiplier.
//   state_t   : control FSM states (IDLE / RUN / DONE)
//   pp_sel_t  : partial-product select code, also the select input of the
//               downstream 4:1 mux bank (0, M, 2M; 2'b11 is never produced)
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        PP_ZERO = 2'b00,
        PP_M    = 2'b01,
        PP_2M   = 2'b10
    } pp_sel_t;

endpackage

// File: rtl/booth_mult_seq_if.sv
// Handshake/data bundle of the Booth multiplier.
//   Start, Signed, MultA, MultB : request side (driven by master)
//   Busy, Done, Product         : status/result (driven by slave)
//   PpSel, PpNeg                : partial-product select for the external mux bank
interface booth_mult_seq_if #(
    parameter int WIDTH = 32
);
    logic                   Start;
    logic                   Signed;
    logic [WIDTH-1:0]       MultA;
    logic [WIDTH-1:0]       MultB;
    logic                   Busy;
    logic                   Done;
    logic [2*WIDTH-1:0]     Product;
    logic [1:0]             PpSel;
    logic                   PpNeg;

    modport master (
        output Start, Signed, MultA, MultB,
        input  Busy, Done, Product, PpSel, PpNeg
    );

    modport slave (
        input  Start, Signed, MultA, MultB,
        output Busy, Done, Product, PpSel, PpNeg
    );
endinterface

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder, purely combinational.
//   triplet : {q[2i+1], q[2i], q[2i-1]}
//   pp_sel  : PP_ZERO / PP_M / PP_2M
//   pp_neg  : negate the selected multiple (always 0 with PP_ZERO)
module booth_recode
    import mult_pkg::*;
(
    input  logic [2:0] triplet,
    output pp_sel_t    pp_sel,
    output logic       pp_neg
);
    always_comb begin
        pp_sel = PP_ZERO;
        pp_neg = 1'b0;
        case (triplet)
            3'b001, 3'b010: begin pp_sel = PP_M;  pp_neg = 1'b0; end
            3'b011:         begin pp_sel = PP_2M; pp_neg = 1'b0; end
            3'b100:         begin pp_sel = PP_2M; pp_neg = 1'b1; end
            3'b101, 3'b110: begin pp_sel = PP_M;  pp_neg = 1'b1; end
            default:        begin pp_sel = PP_ZERO; pp_neg = 1'b0; end
        endcase
    end
endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier (MULT/MULTU control + accumulate).
// Retires two multiplier bits per cycle; WIDTH/2+1 RUN cycles, then one DONE
// cycle with Done pulsed and Product updated.
//   Clk   : rising-edge clock
//   Reset : synchronous, active-high
//   bus   : booth_mult_seq_if.slave (Start/Signed/MultA/MultB in,
//           Busy/Done/Product/PpSel/PpNeg out)
// Optional: define MULT_ZERO_BYPASS_EN to skip RUN when either operand is
// zero at acceptance (Product=0, Done the cycle after the accepting edge).
module booth_mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    booth_mult_seq_if.slave   bus
);
    localparam int E     = WIDTH + 2;        // extended operand width
    localparam int N     = WIDTH / 2 + 1;    // iterations
    localparam int AW    = E + 2;            // accumulator upper half, holds +/-2M
    localparam int CNT_W = $clog2(N);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [E-1:0]         q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [E-1:0]         m_q, m_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;

    pp_sel_t              sel_raw;
    logic                 neg_raw;
    logic [AW-1:0]        pp_mag, pp, sum, acc_sh;
    logic [E-1:0]         q_sh;

    booth_recode u_recode (
        .triplet ({q_q[1], q_q[0], qm1_q}),
        .pp_sel  (sel_raw),
        .pp_neg  (neg_raw)
    );

    // Add the selected multiple to the upper half, then shift {acc, q}
    // right by 2 arithmetically; the retired multiplier bits make room for
    // the low product bits falling out of the accumulator.
    always_comb begin
        pp_mag = '0;
        case (sel_raw)
            PP_M:    pp_mag = {{2{m_q[E-1]}}, m_q};
            PP_2M:   pp_mag = {m_q[E-1], m_q, 1'b0};
            default: pp_mag = '0;
        endcase
        pp     = neg_raw ? (~pp_mag + AW'(1)) : pp_mag;
        sum    = acc_q + pp;
        acc_sh = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_sh   = {sum[1:0], q_q[E-1:2]};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    m_d     = {{2{bus.MultA[WIDTH-1] & bus.Signed}}, bus.MultA};
                    q_d     = {{2{bus.MultB[WIDTH-1] & bus.Signed}}, bus.MultB};
                    qm1_d   = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef MULT_ZERO_BYPASS_EN
                    if (bus.MultA == '0 || bus.MultB == '0) begin
                        // q stays 0, so PpSel reads 00 even if RUN logic is probed
                        q_d       = '0;
                        state_d   = DONE;
                        product_d = '0;
                        done_d    = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                acc_d = acc_sh;
                q_d   = q_sh;
                qm1_d = q_q[1];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    product_d = {acc_sh[WIDTH-3:0], q_sh};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign bus.Busy    = (state_q != IDLE);
    assign bus.Done    = done_q;
    assign bus.Product = product_q;
    // Select code is only meaningful while iterating
    assign bus.PpSel   = (state_q == RUN) ? sel_raw : PP_ZERO;
    assign bus.PpNeg   = (state_q == RUN) ? neg_raw : 1'b0;
endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [1:0] sel_log [0:31];
    logic       neg_log [0:31];

    booth_mult_seq_if #(.WIDTH(W)) bus ();
    booth_mult_seq #(.WIDTH(W)) dut (.Clk(clk), .Reset(rst), .bus(bus));

    always #5 clk = ~clk;

    // Behavioural reference: full-precision multiply of the operands
    function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    // Index of the sampled cycle (0 = cycle right after accepting edge) in which Done shows
    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_ZERO_BYPASS_EN
        if (a == 0 || b == 0) return 0;
`endif
        return W / 2 + 1;
    endfunction

    // Launch one op; optional Start pulse with fresh operands at sample poke_k
    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b, input int poke_k,
                         output logic [63:0] prod, output int lat, output int busy_bad);
        @(negedge clk);
        bus.Start = 1'b1; bus.Signed = s; bus.MultA = a; bus.MultB = b;
        lat = -1; busy_bad = 0; prod = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus.Start = 1'b0; bus.Signed = ~s; bus.MultA = $urandom; bus.MultB = $urandom;
            end
            if (k == poke_k) begin
                bus.Start = 1'b1; bus.MultA = $urandom; bus.MultB = $urandom;
            end else if (k == poke_k + 1) begin
                bus.Start = 1'b0;
            end
            if (k < 32) begin sel_log[k] = bus.PpSel; neg_log[k] = bus.PpNeg; end
            if (bus.Busy !== 1'b1) busy_bad++;
            if (bus.Done === 1'b1) begin lat = k; prod = bus.Product; break; end
        end
        bus.Start = 1'b0;
        @(negedge clk);
        if (bus.Busy !== 1'b0) busy_bad++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.Start = 1'b0; bus.Signed = 1'b0; bus.MultA = '0; bus.MultB = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
        checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.Done); end
        checks++; if (bus.PpSel !== 2'b00) begin errors++; $display("FAIL reset_ppsel got %b want 00", bus.PpSel); end
        checks++; if (bus.PpNeg !== 1'b0) begin errors++; $display("FAIL reset_ppneg got %b want 0", bus.PpNeg); end
        checks++; if (bus.Product !== 64'h0) begin errors++; $display("FAIL reset_product got %h want 0", bus.Product); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [63:0] p; int lat, bb;
        do_op(1'b1, -32'sd3, 32'd7, -10, p, lat, bb);
        checks++; if (p !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL neg3x7 got %h want FFFFFFFFFFFFFFEB", p); end
        checks++; if (lat !== 17) begin errors++; $display("FAIL neg3x7_latency got %0d want 17", lat); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL neg3x7_busy bad_cycles %0d want 0", bb); end
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -10, p, lat, bb);
        checks++; if (p !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL umax got %h want FFFFFFFE00000001", p); end
        do_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -10, p, lat, bb);
        checks++; if (p !== 64'h1) begin errors++; $display("FAIL smax got %h want 1", p); end
        do_op(1'b1, 32'h8000_0000, 32'h8000_0000, -10, p, lat, bb);
        checks++; if (p !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL smin got %h want 4000000000000000", p); end
    endtask

    task automatic test_recode();
        logic [63:0] p; int lat, bb;
        logic [1:0] es; logic en;
        do_op(1'b1, 32'd5, 32'd3, -10, p, lat, bb);
        for (int k = 0; k < 17; k++) begin
            es = (k == 0 || k == 1) ? 2'b01 : 2'b00;
            en = (k == 0);
            checks++;
            if (sel_log[k] !== es || neg_log[k] !== en) begin
                errors++;
                $display("FAIL recode_iter%0d got sel=%b neg=%b want sel=%b neg=%b", k, sel_log[k], neg_log[k], es, en);
            end
        end
        checks++; if (p !== 64'd15) begin errors++; $display("FAIL recode_product got %h want 15", p); end
    endtask

    task automatic test_busy_ignore();
        logic [63:0] p; int lat, bb, seen;
        do_op(1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 3, p, lat, bb);
        checks++; if (p !== ref_mul(1'b1, 32'h1234_5678, 32'hDEAD_BEEF)) begin errors++; $display("FAIL ignore_start got %h want %h", p, ref_mul(1'b1, 32'h1234_5678, 32'hDEAD_BEEF)); end
        checks++; if (lat !== 17) begin errors++; $display("FAIL ignore_latency got %0d want 17", lat); end
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.Done === 1'b1 || bus.Busy === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL ignore_no_second_op active_cycles %0d want 0", seen); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] p; int lat, bb, seen;
        @(negedge clk);
        bus.Start = 1'b1; bus.Signed = 1'b0; bus.MultA = 32'hCAFE_0001; bus.MultB = 32'h0BAD_F00D;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 0) bus.Start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.PpSel !== 2'b00 || bus.PpNeg !== 1'b0 || bus.Product !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b done=%b sel=%b neg=%b prod=%h want all 0", bus.Busy, bus.Done, bus.PpSel, bus.PpNeg, bus.Product);
        end
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.Done === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL reset_mid_no_done done_cycles %0d want 0", seen); end
        do_op(1'b1, 32'h7FFF_FFFF, 32'h8000_0001, -10, p, lat, bb);
        checks++; if (p !== ref_mul(1'b1, 32'h7FFF_FFFF, 32'h8000_0001)) begin errors++; $display("FAIL reset_mid_recover got %h want %h", p, ref_mul(1'b1, 32'h7FFF_FFFF, 32'h8000_0001)); end
    endtask

    task automatic test_zero();
        logic [63:0] p; int lat, bb;
        do_op(1'b1, 32'h0, 32'h1357_9BDF, -10, p, lat, bb);
        checks++; if (p !== 64'h0) begin errors++; $display("FAIL zero_product got %h want 0", p); end
        checks++; if (lat !== exp_lat(32'h0, 32'h1357_9BDF)) begin errors++; $display("FAIL zero_latency got %0d want %0d", lat, exp_lat(32'h0, 32'h1357_9BDF)); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL zero_busy bad_cycles %0d want 0", bb); end
    endtask

    task automatic test_random();
        logic [63:0] p; int lat, bb;
        logic s; logic [31:0] a, b;
        for (int i = 0; i < 1000; i++) begin
            s = 1'($urandom);
            a = ($urandom_range(0, 31) == 0) ? 32'h0 : 32'($urandom);
            b = ($urandom_range(0, 31) == 0) ? 32'h0 : 32'($urandom);
            do_op(s, a, b, -10, p, lat, bb);
            checks++;
            if (p !== ref_mul(s, a, b) || lat !== exp_lat(a, b) || bb !== 0) begin
                errors++;
                $display("FAIL random%0d s=%b a=%h b=%h got %h lat %0d busybad %0d want %h lat %0d", i, s, a, b, p, lat, bb, ref_mul(s, a, b), exp_lat(a, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_recode();
        test_busy_ignore();
        test_reset_mid();
        test_zero();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
